pap_pht_write_scheduler: RTL and testbench

- Owns the single write port of each bank of the per-address counter table (PHT) used by the PAp direction predictor.
- Runs the table-initialisation sweep after reset or on request.
- Arbitrates concurrent training writes from the integer issue lanes onto the bank write ports.
- Holds bank-conflicted writes in a small coalescing queue and provides a drain handshake for flush and checkpoint points.

---
 rtl/pap_pht_write_scheduler_pkg.sv | 29 ++
 rtl/pap_pht_write_scheduler_queue.sv | 121 ++++++++++++
 rtl/pap_pht_write_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_pap_pht_write_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pap_pht_write_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// pap_pht_write_scheduler_pkg
//   Shared types and defaults for the PAp direction-predictor PHT write path.
//   - default table geometry and queue depth
//   - scheduler state encoding
//   - saturating 16-bit add used by the drop counter
// -----------------------------------------------------------------------------
package pap_pht_write_scheduler_pkg;

    localparam int PAP_PHT_ENTRY_NUM   = 1024;
    localparam int PAP_PHT_BANK_NUM    = 2;
    localparam int PAP_PHT_TRAIN_REQ   = 2;
    localparam int PAP_PHT_DATA_W      = 8;
    localparam int PAP_PHT_QUEUE_DEPTH = 4;

    typedef enum logic [1:0] {
        SCHED_INIT  = 2'd0,
        SCHED_RUN   = 2'd1,
        SCHED_DRAIN = 2'd2
    } pht_sched_state_e;

    // Saturates at 0xFFFF instead of wrapping.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/pap_pht_write_scheduler_queue.sv
// -----------------------------------------------------------------------------
// pap_pht_write_queue
//   Coalescing, compacting pending-write queue. Slot 0 is always the oldest
//   entry. Each cycle the entries flagged in 'issue' leave, the survivors
//   compact toward slot 0 in age order, then the enqueue lanes are applied in
//   ascending order: a lane whose index matches a surviving entry (or a new
//   entry created by a lower lane this cycle) overwrites that entry's data,
//   otherwise it is appended at the tail.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        drop every entry (wins over issue/enqueue)
//   issue        per-slot: entry is being written to its bank this cycle
//   enq          per-lane: lane lost arbitration and must be held
//   enq_index    per-lane PHT index
//   enq_data     per-lane entry value
//   valid        per-slot valid (compacted, slot 0 oldest)
//   index, data  per-slot payload
//   count        number of valid entries
// -----------------------------------------------------------------------------
module pap_pht_write_queue
    import pap_pht_write_scheduler_pkg::*;
#(
    parameter int IDX_W     = $clog2(PAP_PHT_ENTRY_NUM),
    parameter int DATA_W    = PAP_PHT_DATA_W,
    parameter int Q_DEPTH   = PAP_PHT_QUEUE_DEPTH,
    parameter int TRAIN_REQ = PAP_PHT_TRAIN_REQ,
    localparam int CNT_W    = $clog2(Q_DEPTH) + 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic [Q_DEPTH-1:0]                issue,
    input  logic [TRAIN_REQ-1:0]              enq,
    input  logic [TRAIN_REQ-1:0][IDX_W-1:0]   enq_index,
    input  logic [TRAIN_REQ-1:0][DATA_W-1:0]  enq_data,
    output logic [Q_DEPTH-1:0]                valid,
    output logic [Q_DEPTH-1:0][IDX_W-1:0]     index,
    output logic [Q_DEPTH-1:0][DATA_W-1:0]    data,
    output logic [CNT_W-1:0]                  count
);

    logic [Q_DEPTH-1:0]             valid_n;
    logic [Q_DEPTH-1:0][IDX_W-1:0]  index_n;
    logic [Q_DEPTH-1:0][DATA_W-1:0] data_n;
    logic [CNT_W-1:0]               tail;
    logic                           hit;

    // NOTE: every signal written here gets a default first, so no path through
    // the loops can leave one unassigned and infer a latch.
    always_comb begin
        valid_n = '0;
        index_n = index;
        data_n  = data;
        tail    = '0;
        hit     = 1'b0;

        // Survivors compact toward slot 0, preserving age order.
        for (int i = 0; i < Q_DEPTH; i++) begin
            if (valid[i] && !issue[i]) begin
                for (int k = 0; k < Q_DEPTH; k++) begin
                    if (CNT_W'(k) == tail) begin
                        valid_n[k] = 1'b1;
                        index_n[k] = index[i];
                        data_n[k]  = data[i];
                    end
                end
                tail = tail + CNT_W'(1);
            end
        end

        // Lanes in ascending order; the search also sees entries created by
        // lower lanes, so a higher lane coalesces into them and its value wins.
        for (int l = 0; l < TRAIN_REQ; l++) begin
            if (enq[l]) begin
                hit = 1'b0;
                for (int k = 0; k < Q_DEPTH; k++) begin
                    if (valid_n[k] && index_n[k] == enq_index[l]) begin
                        data_n[k] = enq_data[l];
                        hit       = 1'b1;
                    end
                end
                if (!hit && tail < CNT_W'(Q_DEPTH)) begin
                    for (int k = 0; k < Q_DEPTH; k++) begin
                        if (CNT_W'(k) == tail) begin
                            valid_n[k] = 1'b1;
                            index_n[k] = enq_index[l];
                            data_n[k]  = enq_data[l];
                        end
                    end
                    tail = tail + CNT_W'(1);
                end
            end
        end

        if (flush) begin
            valid_n = '0;
            tail    = '0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            count <= '0;
        end else begin
            valid <= valid_n;
            count <= tail;
        end
    end

    // NOTE: payload storage has no reset; a slot is only ever read while its
    // valid bit is set, so clearing the valid bits is enough.
    always_ff @(posedge clk) begin
        index <= index_n;
        data  <= data_n;
    end

endmodule

// File: rtl/pap_pht_write_scheduler.sv
// -----------------------------------------------------------------------------
// pap_pht_write_scheduler
//   Owns the single write port of every PHT bank. After reset (or initStart)
//   it sweeps every row of every bank with INIT_VALUE; afterwards it arbitrates
//   training writes from the issue lanes, one winner per bank per cycle, with
//   pending queue entries (oldest first) ahead of new lanes (ascending).
//   Losing lanes are held in a coalescing queue. drainReq empties the queue
//   and acknowledges with a one-cycle drainDone pulse.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   initStart      restart the init sweep, flush the queue (overrides all)
//   trainValid     per-lane training write request
//   trainIndex     per-lane PHT index (bank = low BANK_W bits)
//   trainData      per-lane new entry value
//   trainReady     all lanes are accepted this cycle
//   drainReq       request that the pending queue be emptied
//   drainDone      one-cycle pulse: queue empty after a drain request
//   initBusy       init sweep in progress
//   wrEn           per-bank write enable (registered)
//   wrAddr         per-bank in-bank address = index >> BANK_W (registered)
//   wrData         per-bank write data (registered)
//   queueCount     valid pending-queue entries
//   dropCount      saturating count of lanes discarded while trainReady=0
// -----------------------------------------------------------------------------
module pap_pht_write_scheduler
    import pap_pht_write_scheduler_pkg::*;
#(
    parameter int ENTRY_NUM  = PAP_PHT_ENTRY_NUM,
    parameter int NUM_BANKS  = PAP_PHT_BANK_NUM,
    parameter int TRAIN_REQ  = PAP_PHT_TRAIN_REQ,
    parameter int DATA_W     = PAP_PHT_DATA_W,
    parameter int Q_DEPTH    = PAP_PHT_QUEUE_DEPTH,
    // Every 2-bit counter in the entry set to weakly taken (2'b10).
    parameter logic [DATA_W-1:0] INIT_VALUE = {(DATA_W/2){2'b10}},
    localparam int IDX_W     = $clog2(ENTRY_NUM),
    localparam int BANK_W    = $clog2(NUM_BANKS),
    localparam int ADDR_W    = IDX_W - BANK_W,
    localparam int CNT_W     = $clog2(Q_DEPTH) + 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               initStart,
    input  logic [TRAIN_REQ-1:0]               trainValid,
    input  logic [TRAIN_REQ-1:0][IDX_W-1:0]    trainIndex,
    input  logic [TRAIN_REQ-1:0][DATA_W-1:0]   trainData,
    output logic                               trainReady,
    input  logic                               drainReq,
    output logic                               drainDone,
    output logic                               initBusy,
    output logic [NUM_BANKS-1:0]               wrEn,
    output logic [NUM_BANKS-1:0][ADDR_W-1:0]   wrAddr,
    output logic [NUM_BANKS-1:0][DATA_W-1:0]   wrData,
    output logic [CNT_W-1:0]                   queueCount,
    output logic [15:0]                        dropCount
);

    localparam logic [ADDR_W-1:0] SWEEP_LAST = '1;
    // trainReady needs room for every lane: free slots >= TRAIN_REQ.
    localparam logic [CNT_W-1:0]  READY_MAX  = CNT_W'(Q_DEPTH - TRAIN_REQ);

    pht_sched_state_e state, state_n;
    logic [ADDR_W-1:0] sweep, sweep_n;

    logic [Q_DEPTH-1:0]              q_valid;
    logic [Q_DEPTH-1:0][IDX_W-1:0]   q_index;
    logic [Q_DEPTH-1:0][DATA_W-1:0]  q_data;
    logic [Q_DEPTH-1:0]              issue;

    logic [TRAIN_REQ-1:0] lane_acc;
    logic [TRAIN_REQ-1:0] lane_win;
    logic [TRAIN_REQ-1:0] enq;
    logic                 arb_en;

    logic [NUM_BANKS-1:0]              wr_en_n;
    logic [NUM_BANKS-1:0][ADDR_W-1:0]  wr_addr_n;
    logic [NUM_BANKS-1:0][DATA_W-1:0]  wr_data_n;
    logic [15:0]                       drop_inc;

    // Status outputs come from registered state only, except that initStart
    // masks drainDone in the cycle it is asserted.
    assign trainReady = (state == SCHED_RUN) && (queueCount <= READY_MAX);
    assign initBusy   = (state == SCHED_INIT);
    assign drainDone  = (state == SCHED_DRAIN) && (queueCount == '0) && !initStart;

    assign arb_en   = !initStart && (state != SCHED_INIT);
    assign lane_acc = (trainReady && !initStart) ? trainValid : '0;
    assign enq      = lane_acc & ~lane_win;
    assign drop_inc = trainReady ? 16'd0 : 16'($countones(trainValid));

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_n = state;
        sweep_n = sweep;
        if (initStart) begin
            state_n = SCHED_INIT;
            sweep_n = '0;
        end else begin
            case (state)
                SCHED_INIT: begin
                    sweep_n = sweep + ADDR_W'(1);
                    if (sweep == SWEEP_LAST) state_n = SCHED_RUN;
                end
                SCHED_RUN: begin
                    if (drainReq) state_n = SCHED_DRAIN;
                end
                SCHED_DRAIN: begin
                    if (queueCount == '0) state_n = SCHED_RUN;
                end
                default: begin
                    state_n = SCHED_INIT;
                    sweep_n = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------ per-bank write select
    // Queue entries are scanned before the lanes, so a pending write always
    // reaches its bank ahead of any newer write to the same index.
    always_comb begin
        issue     = '0;
        lane_win  = '0;
        wr_en_n   = '0;
        wr_addr_n = wrAddr;
        wr_data_n = wrData;

        if (!initStart && state == SCHED_INIT) begin
            wr_en_n = '1;
            for (int b = 0; b < NUM_BANKS; b++) begin
                wr_addr_n[b] = sweep;
                wr_data_n[b] = INIT_VALUE;
            end
        end else if (arb_en) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int i = 0; i < Q_DEPTH; i++) begin
                    if (!wr_en_n[b] && q_valid[i] &&
                        q_index[i][BANK_W-1:0] == BANK_W'(b)) begin
                        issue[i]     = 1'b1;
                        wr_en_n[b]   = 1'b1;
                        wr_addr_n[b] = q_index[i][IDX_W-1:BANK_W];
                        wr_data_n[b] = q_data[i];
                    end
                end
                for (int l = 0; l < TRAIN_REQ; l++) begin
                    if (!wr_en_n[b] && lane_acc[l] &&
                        trainIndex[l][BANK_W-1:0] == BANK_W'(b)) begin
                        lane_win[l]  = 1'b1;
                        wr_en_n[b]   = 1'b1;
                        wr_addr_n[b] = trainIndex[l][IDX_W-1:BANK_W];
                        wr_data_n[b] = trainData[l];
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------- registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCHED_INIT;
            sweep     <= '0;
            wrEn      <= '0;
            wrAddr    <= '0;
            wrData    <= '0;
            dropCount <= '0;
        end else begin
            state     <= state_n;
            sweep     <= sweep_n;
            wrEn      <= wr_en_n;
            wrAddr    <= wr_addr_n;
            wrData    <= wr_data_n;
            dropCount <= sat_add16(dropCount, drop_inc);
        end
    end

    // ------------------------------------------------------ pending queue
    pap_pht_write_queue #(
        .IDX_W     (IDX_W),
        .DATA_W    (DATA_W),
        .Q_DEPTH   (Q_DEPTH),
        .TRAIN_REQ (TRAIN_REQ)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (initStart),
        .issue     (issue),
        .enq       (enq),
        .enq_index (trainIndex),
        .enq_data  (trainData),
        .valid     (q_valid),
        .index     (q_index),
        .data      (q_data),
        .count     (queueCount)
    );

endmodule

// File: tb/tb_pap_pht_write_scheduler.sv
module tb_pap_pht_write_scheduler;

    localparam int ENTRY_NUM = 16;
    localparam int NUM_BANKS = 2;
    localparam int TRAIN_REQ = 2;
    localparam int DATA_W    = 8;
    localparam int Q_DEPTH   = 4;
    localparam int IDX_W     = 4;
    localparam int ADDR_W    = 3;
    localparam int CNT_W     = 3;
    localparam int ROWS      = ENTRY_NUM / NUM_BANKS;
    localparam logic [DATA_W-1:0] INIT_VAL = 8'hAA;

    logic                              clk;
    logic                              rst_n;
    logic                              initStart;
    logic [TRAIN_REQ-1:0]              trainValid;
    logic [TRAIN_REQ-1:0][IDX_W-1:0]   trainIndex;
    logic [TRAIN_REQ-1:0][DATA_W-1:0]  trainData;
    logic                              trainReady;
    logic                              drainReq;
    logic                              drainDone;
    logic                              initBusy;
    logic [NUM_BANKS-1:0]              wrEn;
    logic [NUM_BANKS-1:0][ADDR_W-1:0]  wrAddr;
    logic [NUM_BANKS-1:0][DATA_W-1:0]  wrData;
    logic [CNT_W-1:0]                  queueCount;
    logic [15:0]                       dropCount;

    pap_pht_write_scheduler #(
        .ENTRY_NUM  (ENTRY_NUM),
        .NUM_BANKS  (NUM_BANKS),
        .TRAIN_REQ  (TRAIN_REQ),
        .DATA_W     (DATA_W),
        .Q_DEPTH    (Q_DEPTH),
        .INIT_VALUE (INIT_VAL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .initStart  (initStart),
        .trainValid (trainValid),
        .trainIndex (trainIndex),
        .trainData  (trainData),
        .trainReady (trainReady),
        .drainReq   (drainReq),
        .drainDone  (drainDone),
        .initBusy   (initBusy),
        .wrEn       (wrEn),
        .wrAddr     (wrAddr),
        .wrData     (wrData),
        .queueCount (queueCount),
        .dropCount  (dropCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------ reference model
    // The model keeps the pending writes as an age-ordered list and applies
    // the arbitration rules directly; expected bank writes and expected
    // per-cycle status are pushed to the scoreboard queues.
    typedef enum {M_INIT, M_RUN, M_DRAIN} m_state_e;
    typedef struct { int idx; int data; } pend_t;
    typedef struct { int bank; int cyc; int addr; int data; } wr_t;
    typedef struct { int ready; int busy; int done; int qcount; int drop; } st_t;

    m_state_e m_state = M_INIT;
    int       m_sweep = 0;
    int       m_drop  = 0;
    pend_t    pend[$];
    wr_t      exp_wr[$];
    st_t      exp_st[$];

    task automatic push_wr(input int bank, input int addr, input int data);
        wr_t w;
        w.bank = bank; w.cyc = cyc + 1; w.addr = addr; w.data = data;
        exp_wr.push_back(w);
    endtask

    task automatic model_step(input int ready);
        int    nv;
        int    old;
        int    b;
        bit    busy[NUM_BANKS];
        bit    found;
        pend_t keep[$];
        pend_t lose[$];
        pend_t p;

        nv = 0;
        for (int l = 0; l < TRAIN_REQ; l++) nv += int'(trainValid[l]);
        if (ready == 0) m_drop = (m_drop + nv > 65535) ? 65535 : m_drop + nv;

        if (initStart) begin
            pend.delete();
            m_state = M_INIT;
            m_sweep = 0;
            return;
        end

        if (m_state == M_INIT) begin
            for (int k = 0; k < NUM_BANKS; k++) push_wr(k, m_sweep, int'(INIT_VAL));
            if (m_sweep == ROWS - 1) m_state = M_RUN;
            m_sweep = (m_sweep + 1) % ROWS;
            return;
        end

        old = pend.size();
        for (int k = 0; k < NUM_BANKS; k++) busy[k] = 1'b0;
        foreach (pend[i]) begin
            b = pend[i].idx % NUM_BANKS;
            if (!busy[b]) begin
                busy[b] = 1'b1;
                push_wr(b, pend[i].idx / NUM_BANKS, pend[i].data);
            end else begin
                keep.push_back(pend[i]);
            end
        end
        if (ready != 0) begin
            for (int l = 0; l < TRAIN_REQ; l++) begin
                if (trainValid[l]) begin
                    b = int'(trainIndex[l]) % NUM_BANKS;
                    if (!busy[b]) begin
                        busy[b] = 1'b1;
                        push_wr(b, int'(trainIndex[l]) / NUM_BANKS, int'(trainData[l]));
                    end else begin
                        p.idx = int'(trainIndex[l]);
                        p.data = int'(trainData[l]);
                        lose.push_back(p);
                    end
                end
            end
        end
        foreach (lose[j]) begin
            found = 1'b0;
            foreach (keep[k]) begin
                if (keep[k].idx == lose[j].idx) begin
                    keep[k].data = lose[j].data;
                    found = 1'b1;
                end
            end
            if (!found) keep.push_back(lose[j]);
        end
        pend = keep;

        if (m_state == M_RUN && drainReq) m_state = M_DRAIN;
        else if (m_state == M_DRAIN && old == 0) m_state = M_RUN;
    endtask

    // Called at posedge+1 with inputs for the coming edge already driven.
    task automatic cycle_step();
        st_t s;
        s.ready  = (m_state == M_RUN && (Q_DEPTH - pend.size()) >= TRAIN_REQ) ? 1 : 0;
        s.busy   = (m_state == M_INIT) ? 1 : 0;
        s.done   = (m_state == M_DRAIN && pend.size() == 0 && !initStart) ? 1 : 0;
        s.qcount = pend.size();
        s.drop   = m_drop;
        exp_st.push_back(s);
        model_step(s.ready);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v0, input int i0, input int d0,
                         input bit v1, input int i1, input int d1,
                         input bit ist, input bit drq);
        trainValid    = {v1, v0};
        trainIndex[0] = IDX_W'(i0);
        trainIndex[1] = IDX_W'(i1);
        trainData[0]  = DATA_W'(d0);
        trainData[1]  = DATA_W'(d1);
        initStart     = ist;
        drainReq      = drq;
        cycle_step();
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // ------------------------------------------------------------- monitor
    always @(negedge clk) begin : monitor
        st_t                 s;
        wr_t                 w;
        logic [NUM_BANKS-1:0] ee;
        int                  ea[NUM_BANKS];
        int                  ed[NUM_BANKS];

        if (exp_st.size() > 0) begin
            s = exp_st.pop_front();
            check("trainReady", 64'(trainReady), 64'(s.ready));
            check("initBusy",   64'(initBusy),   64'(s.busy));
            check("drainDone",  64'(drainDone),  64'(s.done));
            check("queueCount", 64'(queueCount), 64'(s.qcount));
            check("dropCount",  64'(dropCount),  64'(s.drop));
        end

        ee = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            ea[k] = 0;
            ed[k] = 0;
        end
        while (exp_wr.size() > 0 && exp_wr[0].cyc <= cyc) begin
            w = exp_wr.pop_front();
            ee[w.bank] = 1'b1;
            ea[w.bank] = w.addr;
            ed[w.bank] = w.data;
        end
        check("wrEn", 64'(wrEn), 64'(ee));
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (ee[k]) begin
                check($sformatf("wrAddr[%0d]", k), 64'(wrAddr[k]), 64'(ea[k]));
                check($sformatf("wrData[%0d]", k), 64'(wrData[k]), 64'(ed[k]));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ------------------------------------------------------------ stimulus
    initial begin : stim
        int  drain_hold;
        bit  v0, v1, ist, drq;
        int  i0, i1, d0, d1;

        rst_n      = 1'b0;
        initStart  = 1'b0;
        drainReq   = 1'b0;
        trainValid = '0;
        trainIndex = '0;
        trainData  = '0;
        repeat (3) @(posedge clk);
        #1;

        check("rst_wrEn",       64'(wrEn),       64'd0);
        check("rst_wrAddr",     64'(wrAddr),     64'd0);
        check("rst_wrData",     64'(wrData),     64'd0);
        check("rst_initBusy",   64'(initBusy),   64'd1);
        check("rst_trainReady", 64'(trainReady), 64'd0);
        check("rst_drainDone",  64'(drainDone),  64'd0);
        check("rst_dropCount",  64'(dropCount),  64'd0);
        check("rst_queueCount", 64'(queueCount), 64'd0);

        rst_n = 1'b1;

        // Init sweep over 8 rows, then settle.
        idle(ROWS + 2);

        // No conflict: bank0 and bank1 at addr 2.
        drive(1, 4, 'h44, 1, 5, 'h55, 0, 0);
        idle(2);

        // Conflict on bank0: idx6 first, idx8 one cycle later.
        drive(1, 6, 'h11, 1, 8, 'h22, 0, 0);
        idle(3);

        // Coalesce: idx8=0x22 queued behind idx4, then overwritten with 0x33.
        drive(1, 0, 'h01, 1, 2, 'h02, 0, 0);
        drive(1, 4, 'h03, 1, 8, 'h22, 0, 0);
        drive(1, 8, 'h33, 0, 0, 0, 0, 0);
        idle(4);

        // Backpressure: fill to 3, lanes dropped, then drain.
        drive(1, 0, 'h10, 1, 2, 'h20, 0, 0);
        drive(1, 4, 'h30, 1, 6, 'h40, 0, 0);
        drive(1, 8, 'h50, 1, 10, 'h60, 0, 0);
        drive(1, 12, 'h70, 1, 14, 'h80, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        idle(6);

        // Drain request with an already-empty queue.
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        idle(3);

        // initStart mid-drain with three entries queued.
        drive(1, 0, 'h91, 1, 2, 'h92, 0, 0);
        drive(1, 4, 'h93, 1, 6, 'h94, 0, 0);
        drive(1, 8, 'h95, 1, 10, 'h96, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        idle(3);
        drive(1, 3, 'h01, 1, 7, 'h02, 0, 0);
        idle(ROWS + 2);

        // Randomized traffic with drains, rare re-inits and small index range
        // to provoke conflicts and coalescing.
        drain_hold = 0;
        for (int n = 0; n < 1500; n++) begin
            v0  = ($urandom_range(0, 99) < 65);
            v1  = ($urandom_range(0, 99) < 65);
            i0  = int'($urandom_range(0, 9));
            i1  = int'($urandom_range(0, 9));
            d0  = int'($urandom_range(0, 255));
            d1  = int'($urandom_range(0, 255));
            ist = ($urandom_range(0, 399) == 0);
            if (drain_hold == 0 && $urandom_range(0, 99) < 4)
                drain_hold = int'($urandom_range(1, 6));
            drq = (drain_hold > 0);
            if (drain_hold > 0) drain_hold--;
            drive(v0, i0, d0, v1, i1, d1, ist, drq);
        end

        idle(ROWS + 12);
        @(negedge clk);
        #1;
        check("leftover_expected_writes", 64'(exp_wr.size()), 64'd0);
        check("leftover_expected_status", 64'(exp_st.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
